// File: rtl/mems_dac_spi_master.sv
// SPI master serialising 24-bit quad-DAC commands MSB-first on SYNC/SCLK/MOSI.
// Optional LDAC strobe after each frame when MEMS_SPI_LDAC_EN is defined.
module mems_dac_spi_master #(
  parameter int DATA_W   = 24,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2,
  parameter int LDAC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              sync_n,
  output logic              ldac_n
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = max2(max2(2*CLK_DIV, CS_SETUP), max2(max2(CS_HOLD, CS_IDLE), LDAC_W));
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] PER_END   = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] RISE_PRE  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(CS_IDLE - 1);
  localparam logic [CW-1:0] LDAC_END  = CW'(LDAC_W - 1);
  localparam logic [BW-1:0] BIT_END   = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SETUP = 3'd1, S_SHIFT = 3'd2, S_HOLD = 3'd3, S_GAP = 3'd4, S_LDAC = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic busy_d, done_d, sclk_d, mosi_d, sync_n_d, ldac_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b1;
      mosi    <= 1'b0;
      sync_n  <= 1'b1;
      ldac_n  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      busy    <= busy_d;
      done    <= done_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      sync_n  <= sync_n_d;
      ldac_n  <= ldac_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: if (cnt_q == SETUP_END) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == PER_END && bit_q == BIT_END) state_d = S_HOLD;
      S_HOLD:  if (cnt_q == HOLD_END) state_d = S_GAP;
`ifdef MEMS_SPI_LDAC_EN
      S_GAP:   if (cnt_q == GAP_END) state_d = S_LDAC;
      S_LDAC:  if (cnt_q == LDAC_END) state_d = S_IDLE;
`else
      S_GAP:   if (cnt_q == GAP_END) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Counters restart on every state entry; the shift happens on the cycle sclk rises.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_d != state_q || state_d == S_IDLE) begin
      cnt_d = '0;
      bit_d = '0;
    end else if (state_q == S_SHIFT && cnt_q == PER_END) begin
      cnt_d = '0;
      bit_d = bit_q + 1'b1;
    end
    if (state_q == S_IDLE && state_d == S_SETUP)
      shreg_d = data_in;
    else if (state_q == S_SHIFT && state_d == S_SHIFT && cnt_q == RISE_PRE)
      shreg_d = shreg_q << 1;
  end

  always_comb begin
    busy_d   = (state_d != S_IDLE);
    sync_n_d = !(state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD);
    sclk_d   = !(state_d == S_SHIFT && cnt_d < HALF);
    mosi_d   = (state_d == S_SETUP || state_d == S_SHIFT) ? shreg_d[DATA_W-1] : 1'b0;
`ifdef MEMS_SPI_LDAC_EN
    done_d   = (state_d == S_LDAC && cnt_d == LDAC_END);
    ldac_n_d = (state_d != S_LDAC);
`else
    done_d   = (state_d == S_GAP && cnt_d == GAP_END);
    ldac_n_d = 1'b1;
`endif
  end

endmodule

// File: tb/tb_mems_dac_spi_master.sv
// Randomised bench for mems_dac_spi_master: a pin-level monitor rebuilds each SPI
// frame and compares it and its timing against a queue of accepted command words.
module tb_mems_dac_spi_master;
  localparam int DATA_W = 24, CLK_DIV = 2, CS_SETUP = 2, CS_HOLD = 2, CS_IDLE = 2, LDAC_W = 4;
`ifdef MEMS_SPI_LDAC_EN
  localparam int LDAC_CYC = LDAC_W;
`else
  localparam int LDAC_CYC = 0;
`endif
  localparam int BUSY_LEN = CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD + CS_IDLE + LDAC_CYC;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic busy, done, sclk, mosi, sync_n, ldac_n;

  mems_dac_spi_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
    .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .LDAC_W(LDAC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .sync_n(sync_n), .ldac_n(ldac_n));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  int sent = 0, frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pin-level monitor: frames, busy/done timing, inter-frame gap, LDAC pulse.
  logic [DATA_W-1:0] bits;
  int nbits, blen, dcnt, hi_cnt, t_rise, lcnt;
  logic had_frame, sclk_p, sync_p, busy_p, done_p, ldac_p;

  always @(negedge clk) begin
    if (!rst_n) begin
      bits = '0; nbits = 0; blen = 0; dcnt = 0; hi_cnt = 0; t_rise = 0; lcnt = 0;
      had_frame = 0; frames = 0;
      sclk_p = 1; sync_p = 1; busy_p = 0; done_p = 0; ldac_p = 1;
    end else begin
      if (sclk_p && !sclk) begin
        bits = {bits[DATA_W-2:0], mosi};
        nbits++;
      end
      if (sync_p && !sync_n) begin
        if (had_frame) chk("gap_ge_idle", 32'(hi_cnt >= CS_IDLE), 1);
        bits = '0; nbits = 0;
      end
      if (!sync_p && sync_n) begin
        chk("nbits", nbits, DATA_W);
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else chk("frame_word", bits, exp_q.pop_front());
        frames++; had_frame = 1; hi_cnt = 0; t_rise = 0;
      end else t_rise++;
      if (sync_n) hi_cnt++;
      if (busy) begin
        blen++;
        if (done) dcnt++;
      end
      if (!busy && done) chk("done_while_idle", 1, 0);
      if (busy_p && !busy) begin
        chk("busy_len", blen, BUSY_LEN);
        chk("done_count", dcnt, 1);
        chk("done_last_busy", done_p, 1);
        blen = 0; dcnt = 0;
      end
`ifdef MEMS_SPI_LDAC_EN
      if (!ldac_n && !sync_n) chk("ldac_during_sync", 1, 0);
      if (ldac_p && !ldac_n) chk("ldac_start", t_rise, CS_IDLE);
      if (!ldac_n) lcnt++;
      if (!ldac_p && ldac_n) begin
        chk("ldac_width", lcnt, LDAC_W);
        lcnt = 0;
      end
`else
      if (!ldac_n) chk("ldac_tied_high", ldac_n, 1);
`endif
      sclk_p = sclk; sync_p = sync_n; busy_p = busy; done_p = done; ldac_p = ldac_n;
    end
  end

  task automatic send(input logic [DATA_W-1:0] w);
    for (int k = 0; k < 1000 && busy; k++) @(negedge clk);
    if (busy) chk("send_timeout", 0, 1);
    start = 1; data_in = w;
    exp_q.push_back(w); sent++;
    @(negedge clk);
    start = 0; data_in = $urandom;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000 && busy; k++) @(negedge clk);
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sclk"}, sclk, 1);
    chk({tag, "_sync_n"}, sync_n, 1);
    chk({tag, "_ldac_n"}, ldac_n, 1);
    chk({tag, "_mosi"}, mosi, 0);
  endtask

  initial begin
    // Reset held with random activity on the inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom); data_in = $urandom;
      if (i >= 2) chk_reset_outs("reset");
    end
    start = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // Single frame, then a start pulse mid-frame that must be ignored
    send(24'h3F0015);
    repeat (8) @(negedge clk);
    chk("busy_mid", busy, 1);
    start = 1; data_in = 24'hFFFFFF;
    @(negedge clk); start = 0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_second_frame", busy, 0);

    // Sweep controller sequence issued back-to-back
    send(24'h280001);
    send(24'h380001);
    for (int ch = 0; ch < 4; ch++) send({8'(8'h18 + ch), 16'($urandom)});
    wait_idle();

    // Random words with random idle spacing
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(24'($urandom));
    end
    wait_idle();

    // Abort at bit 12 with an asynchronous reset
    send(24'($urandom));
    repeat (CS_SETUP + 12*2*CLK_DIV - 1) @(negedge clk);
    chk("abort_in_frame", sync_n, 0);
    #1 rst_n = 0;
    #1 chk_reset_outs("abort");
    exp_q.delete(); sent = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("abort_held");
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("no_resume", sync_n, 1);
    send(24'hA5A5A5);
    wait_idle();
    repeat (4) @(negedge clk);

    chk("pending_words", exp_q.size(), 0);
    chk("frame_total", frames, sent);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
